iterative_divider: RTL and testbench

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

---
 rtl/iterative_divider.sv | 177 +++++++++++++++++
 tb/tb_iterative_divider.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring integer divider, signed/unsigned, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: trivial operands complete on the acceptance edge.
module iterative_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             accept;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic             early;
    logic [WIDTH-1:0] early_q;
    logic [WIDTH-1:0] early_r;

    // Operand magnitudes and one restoring step on the current partial remainder.
    always_comb begin
        mag_a    = (in_signed && in_dividend[WIDTH-1]) ? WIDTH'(-in_dividend) : in_dividend;
        mag_b    = (in_signed && in_divisor[WIDTH-1])  ? WIDTH'(-in_divisor)  : in_divisor;
        rem_sh   = {rem, quo[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, dvs});
        rem_step = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ge};
        // A zero divisor leaves rem = |dividend|, so the sign fix restores the original dividend.
        q_fix    = div_zero ? '1 : (neg_q ? WIDTH'(-quo_step) : quo_step);
        r_fix    = neg_r ? WIDTH'(-rem_step) : rem_step;
    end

`ifdef DIV_EARLY_OUT_EN
    always_comb begin
        early   = 1'b0;
        early_q = '0;
        early_r = '0;
        if (in_divisor == '0) begin
            early   = 1'b1;
            early_q = '1;
            early_r = in_dividend;
        end else if (in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (in_divisor == '1)) begin
            early   = 1'b1;
            early_q = in_dividend;
            early_r = '0;
        end else if (mag_a < mag_b) begin
            early   = 1'b1;
            early_q = '0;
            early_r = in_dividend;
        end
    end
`else
    assign early   = 1'b0;
    assign early_q = '0;
    assign early_r = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and datapath strobes; flush overrides accept, step and consume.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = early ? DONE : BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            accept     = 1'b0;
            step       = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_tag       <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
            if (accept) begin
                cnt      <= '0;
                rem      <= '0;
                quo      <= mag_a;
                dvs      <= mag_b;
                neg_q    <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                neg_r    <= in_signed && in_dividend[WIDTH-1];
                div_zero <= (in_divisor == '0);
                out_tag  <= in_tag;
                if (early) begin
                    out_quotient  <= early_q;
                    out_remainder <= early_r;
                end
            end
            if (step) begin
                cnt <= cnt + CNT_W'(1);
                rem <= rem_step;
                quo <= quo_step;
            end
            if (finish) begin
                out_quotient  <= q_fix;
                out_remainder <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed vectors, backpressure, flush and async reset.
module tb_iterative_divider;

    localparam int LAT = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SP = 0;   // result visible right after the acceptance edge
`else
    localparam int LAT_SP = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic [5:0]  out_tag;
    logic        busy;

    iterative_divider #(.WIDTH(32), .TAG_W(6)) dut (
        .wb_clk_i     (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_tag       (in_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [5:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-low-phase, pops on every handshake.
    initial begin : monitor
        exp_t e;
        bit   seen;
        int   first;
        seen  = 1'b0;
        first = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!out_valid) seen = 1'b0;
            else if (!seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: q=%h r=%h with no pending request", out_quotient, out_remainder);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",  out_quotient,  e.q);
                    chk("remainder", out_remainder, e.r);
                    chk("tag",       32'(out_tag),  32'(e.tag));
                    chk("latency",   32'(first - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tg, input logic [31:0] eq, input logic [31:0] er,
                         input int lat, input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_signed   = sg;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = tg;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.q = eq; e.r = er; e.tag = tg; e.acc = cyc; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic watch_quiet(input string name);
        int hits;
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk(name, 32'(hits), 32'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_in_ready"},  32'(in_ready),  32'd1);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_busy"},      32'(busy),      32'd0);
        chk({name, "_q"},         out_quotient,   32'd0);
        chk({name, "_r"},         out_remainder,  32'd0);
        chk({name, "_tag"},       32'(out_tag),   32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Directed vectors: sg, dividend, divisor, tag, q, r, latency
        issue(1'b0, 32'd100,        32'd7,          6'd5,  32'd14,         32'd2,          LAT,    1'b1);
        issue(1'b1, 32'hFFFFFFF9,   32'd2,          6'd6,  32'hFFFFFFFD,   32'hFFFFFFFF,   LAT,    1'b1);
        issue(1'b1, 32'd7,          32'hFFFFFFFE,   6'd7,  32'hFFFFFFFD,   32'd1,          LAT,    1'b1);
        issue(1'b0, 32'd5,          32'd0,          6'd8,  32'hFFFFFFFF,   32'd5,          LAT_SP, 1'b1);
        issue(1'b1, 32'hFFFFFFFB,   32'd0,          6'd9,  32'hFFFFFFFF,   32'hFFFFFFFB,   LAT_SP, 1'b1);
        issue(1'b1, 32'h80000000,   32'hFFFFFFFF,   6'd10, 32'h80000000,   32'd0,          LAT_SP, 1'b1);
        issue(1'b0, 32'd3,          32'd10,         6'd11, 32'd0,          32'd3,          LAT_SP, 1'b1);
        issue(1'b0, 32'hFFFFFFFF,   32'd16,         6'd12, 32'h0FFFFFFF,   32'd15,         LAT,    1'b1);
        issue(1'b0, 32'h80000000,   32'hFFFFFFFF,   6'd13, 32'd0,          32'h80000000,   LAT_SP, 1'b1);
        drain();

        // Backpressure: result held 10 cycles while the next request waits on in_valid.
        out_ready = 1'b0;
        issue(1'b0, 32'd1000, 32'd10, 6'd20, 32'd100, 32'd0, LAT, 1'b1);
        @(negedge clk);
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'd20;
        in_divisor  = 32'd6;
        in_tag      = 6'd21;
        wait_valid("bp_valid");
        repeat (10) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_q",     out_quotient,   32'd100);
            chk("bp_hold_tag",   32'(out_tag),   32'd20);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("gap_in_ready",  32'(in_ready),  32'd1);
        chk("gap_out_valid", 32'(out_valid), 32'd0);
        chk("gap_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        begin
            exp_t e;
            e.q = 32'd3; e.r = 32'd2; e.tag = 6'd21; e.acc = cyc; e.lat = LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("held_accept_busy",     32'(busy),     32'd1);
        chk("held_accept_in_ready", 32'(in_ready), 32'd0);
        drain();

        // Flush on the edge performing step 12.
        issue(1'b0, 32'd50, 32'd5, 6'd30, 32'd0, 32'd0, LAT, 1'b0);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy_busy",     32'(busy),     32'd0);
        watch_quiet("flush_busy_no_valid");

        // Flush while a result waits in DONE.
        out_ready = 1'b0;
        issue(1'b0, 32'd8, 32'd2, 6'd31, 32'd0, 32'd0, LAT, 1'b0);
        wait_valid("flush_done_valid");
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_done_out_valid", 32'(out_valid), 32'd0);
        chk("flush_done_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;

        // Asynchronous reset mid-cycle during step 20.
        issue(1'b0, 32'd77, 32'd7, 6'd40, 32'd0, 32'd0, LAT, 1'b0);
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("reset_no_valid");

        issue(1'b0, 32'd9, 32'd3, 6'd41, 32'd3, 32'd0, LAT, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
